// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants: pushbutton channel indices, default timing derived from the
// system clock frequency, the autorepeat state type and a counter-width helper.
package stopwatch_pkg;

    localparam int unsigned CLK_FREQ_MHZ = 100;

    localparam int unsigned N_BTN          = 3;
    localparam int unsigned BTN_START_STOP = 0;
    localparam int unsigned BTN_SET        = 1;
    localparam int unsigned BTN_CHANGE     = 2;

    // 10 ms debounce, 500 ms before first autorepeat, 200 ms between repeats
    localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_FREQ_MHZ * 10_000;
    localparam int unsigned HOLD_CYCLES_DEF     = CLK_FREQ_MHZ * 500_000;
    localparam int unsigned REPEAT_CYCLES_DEF   = CLK_FREQ_MHZ * 200_000;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRepeat
    } rep_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One pushbutton channel: 2-FF synchroniser, counter debounce and optional hold-to-autorepeat,
// producing a clean active-high level plus registered single-cycle press/release pulses.
module button_debounce_ch
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
    parameter bit          REPEAT_EN       = 1'b0
) (
    input  logic clk100_i,
    input  logic rstn_i,
    input  logic btn_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned DbW   = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HoldW = cnt_width(HOLD_CYCLES);
    localparam int unsigned RptW  = cnt_width(REPEAT_CYCLES);
    localparam int unsigned RepW  = (HoldW > RptW) ? HoldW : RptW;

    localparam logic [DbW-1:0]  DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RepW-1:0] HoldLast = RepW'(HOLD_CYCLES - 1);
    localparam logic [RepW-1:0] RptLast  = RepW'(REPEAT_CYCLES - 1);

    logic            s1_q, s1_d;
    logic            s2_q, s2_d;
    logic            stable_q, stable_d;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    rep_state_e      rep_state_q, rep_state_d;
    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic            sample_pressed;
    logic            rise;
    logic            fall;

    always_comb begin
        s1_d           = btn_n_i;
        s2_d           = s1_q;
        stable_d       = stable_q;
        db_cnt_d       = '0;
        rep_state_d    = rep_state_q;
        rep_cnt_d      = rep_cnt_q;
        sample_pressed = ~s2_q;

        // Any sample agreeing with the accepted level restarts the stability count
        if (sample_pressed != stable_q) begin
            if (db_cnt_q == DbLast) begin
                stable_d = sample_pressed;
            end else begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
        end

        rise      = stable_d & ~stable_q;
        fall      = ~stable_d & stable_q;
        press_d   = rise;
        release_d = fall;

        if (REPEAT_EN) begin
            if (fall) begin
                rep_state_d = StIdle;
                rep_cnt_d   = '0;
            end else begin
                unique case (rep_state_q)
                    StIdle: begin
                        rep_cnt_d = '0;
                        if (rise) begin
                            rep_state_d = StHold;
                        end
                    end
                    StHold: begin
                        if (rep_cnt_q == HoldLast) begin
                            press_d     = 1'b1;
                            rep_state_d = StRepeat;
                            rep_cnt_d   = '0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + RepW'(1);
                        end
                    end
                    StRepeat: begin
                        if (rep_cnt_q == RptLast) begin
                            press_d   = 1'b1;
                            rep_cnt_d = '0;
                        end else begin
                            rep_cnt_d = rep_cnt_q + RepW'(1);
                        end
                    end
                    default: begin
                        rep_state_d = StIdle;
                        rep_cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            stable_q    <= 1'b0;
            db_cnt_q    <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            rep_state_q <= StIdle;
            rep_cnt_q   <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            stable_q    <= stable_d;
            db_cnt_q    <= db_cnt_d;
            press_q     <= press_d;
            release_q   <= release_d;
            rep_state_q <= rep_state_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end

    assign level_o   = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Stopwatch pushbutton front-end: one independent synchronise/debounce/autorepeat channel
// per raw active-low board button.
module button_conditioner #(
    parameter int unsigned      N_BTN           = stopwatch_pkg::N_BTN,
    parameter int unsigned      DEBOUNCE_CYCLES = stopwatch_pkg::DEBOUNCE_CYCLES_DEF,
    parameter int unsigned      HOLD_CYCLES     = stopwatch_pkg::HOLD_CYCLES_DEF,
    parameter int unsigned      REPEAT_CYCLES   = stopwatch_pkg::REPEAT_CYCLES_DEF,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 3'b100
) (
    input  logic             clk100_i,
    input  logic             rstn_i,
    input  logic [N_BTN-1:0] btn_n_i,
    output logic [N_BTN-1:0] level_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_ch (
            .clk100_i  (clk100_i),
            .rstn_i    (rstn_i),
            .btn_n_i   (btn_n_i[i]),
            .level_o   (level_o[i]),
            .press_o   (press_o[i]),
            .release_o (release_o[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected press/release events (channel, edge number)
// are queued as stimulus is applied and compared against events captured from the outputs.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       rstn;
    logic [2:0] btn_n;
    logic [2:0] level;
    logic [2:0] press;
    logic [2:0] rel;

    int unsigned cyc     = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    typedef struct packed {
        logic        is_rel;
        logic [1:0]  ch;
        logic [31:0] cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    button_conditioner #(
        .N_BTN           (3),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .REPEAT_CYCLES   (8),
        .REPEAT_MASK     (3'b100)
    ) dut (
        .clk100_i  (clk),
        .rstn_i    (rstn),
        .btn_n_i   (btn_n),
        .level_o   (level),
        .press_o   (press),
        .release_o (rel)
    );

    always #5 clk = ~clk;

    // cyc == number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (press[i]) obs_q.push_back('{1'b0, 2'(i), cyc});
            if (rel[i])   obs_q.push_back('{1'b1, 2'(i), cyc});
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic is_rel, input int ch, input int unsigned c);
        exp_q.push_back('{is_rel, 2'(ch), c});
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_events(input string tag);
        int n;
        check($sformatf("%s.count", tag), 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.ev%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int unsigned c;
        int unsigned r;
        int unsigned p;

        // 1: reset with all buttons held, then fresh press once reset lifts
        rstn  = 1'b0;
        btn_n = 3'b000;
        step(3);
        check("rst.level", 64'(level), 64'(3'b000));
        check("rst.press", 64'(press), 64'(3'b000));
        check("rst.rel", 64'(rel), 64'(3'b000));
        c    = cyc;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) expect_ev(1'b0, i, c + 6);
        step(5);
        check("rst.level_pre", 64'(level), 64'(3'b000));
        step(1);
        check("rst.level_up", 64'(level), 64'(3'b111));
        step(4);
        r     = cyc;
        btn_n = 3'b111;
        for (int i = 0; i < 3; i++) expect_ev(1'b1, i, r + 6);
        step(12);
        check("rst.level_down", 64'(level), 64'(3'b000));
        check_events("reset");

        // 2: clean 200 ns press on set
        c        = cyc;
        btn_n[1] = 1'b0;
        expect_ev(1'b0, 1, c + 6);
        step(20);
        r        = cyc;
        btn_n[1] = 1'b1;
        expect_ev(1'b1, 1, r + 6);
        step(3);
        check("clean.level_held", 64'(level), 64'(3'b010));
        step(5);
        check("clean.level_rel", 64'(level), 64'(3'b000));
        check_events("clean");

        // 3: bouncing start_stop, then lone 30 ns glitches
        for (int k = 0; k < 10; k++) begin
            btn_n[0] = (k % 2 == 0) ? 1'b0 : 1'b1;
            step(2);
        end
        c        = cyc;
        btn_n[0] = 1'b0;
        expect_ev(1'b0, 0, c + 6);
        step(10);
        r        = cyc;
        btn_n[0] = 1'b1;
        expect_ev(1'b1, 0, r + 6);
        step(10);
        check_events("bounce");
        for (int k = 0; k < 3; k++) begin
            btn_n[0] = 1'b0;
            step(3);
            btn_n[0] = 1'b1;
            step(5);
        end
        check("glitch.level", 64'(level), 64'(3'b000));
        check_events("glitch");

        // 4: change held 800 ns; repeats stop once the release is accepted at r+6
        c        = cyc;
        btn_n[2] = 1'b0;
        expect_ev(1'b0, 2, c + 6);
        for (p = c + 26; p < c + 86; p += 8) expect_ev(1'b0, 2, p);
        expect_ev(1'b1, 2, c + 86);
        step(80);
        btn_n[2] = 1'b1;
        step(12);
        check("repeat.level", 64'(level), 64'(3'b000));
        check_events("repeat");

        // 5: set held 800 ns is masked from autorepeat
        c        = cyc;
        btn_n[1] = 1'b0;
        expect_ev(1'b0, 1, c + 6);
        step(80);
        btn_n[1] = 1'b1;
        expect_ev(1'b1, 1, c + 86);
        step(12);
        check_events("masked");

        // 6: simultaneous press, then reset in the middle of the hold period
        c     = cyc;
        btn_n = 3'b000;
        for (int i = 0; i < 3; i++) expect_ev(1'b0, i, c + 6);
        step(6);
        check("simul.press", 64'(press), 64'(3'b111));
        step(10);
        rstn = 1'b0;
        #1;
        check("midrst.level", 64'(level), 64'(3'b000));
        check("midrst.press", 64'(press), 64'(3'b000));
        btn_n = 3'b111;
        step(3);
        rstn = 1'b1;
        step(40);
        check("midrst.level_after", 64'(level), 64'(3'b000));
        check_events("simul_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
